// File: rtl/decoder_pkg.sv
// Shared types and helpers for the registered one-hot decoder.
// Pure declarations: no logic, no latency, no flow control.
package decoder_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    localparam int MAX_SEL_W = 8;

    function automatic int out_w(input int sel_w);
        return 1 << sel_w;
    endfunction

endpackage

// File: rtl/decoder_onehot.sv
// Combinational SEL_W-to-2^SEL_W one-hot decode with enable gating.
// Zero latency; no flow control of its own.
module decoder_onehot
    import decoder_pkg::*;
#(
    parameter  int SEL_W = 3,
    localparam int OUT_W = out_w(SEL_W)
) (
    input  logic [SEL_W-1:0] I,
    input  logic             en,
    output logic [OUT_W-1:0] O
);

    // The shift is done at full output width so the top bit is reachable.
    assign O = en ? (OUT_W'(1) << I) : '0;

endmodule

// File: rtl/decoder_pipe.sv
// Registered one-hot decoder with an IDLE/SWEEP FSM; 1-cycle latency.
// Single output register with pass-through refill; a stalled output freezes the word and the sweep counter.
module decoder_pipe
    import decoder_pkg::*;
#(
    parameter  int SEL_W = 3,
    localparam int OUT_W = out_w(SEL_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] in_sel,
    input  logic             in_en,
    input  logic             sweep_start,
    output logic             sweep_busy,
    output logic             sweep_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] O,
    output logic [SEL_W-1:0] out_idx
);

    state_t           r_state;
    logic [SEL_W-1:0] r_cnt;
    logic [SEL_W-1:0] r_idx;
    logic [OUT_W-1:0] r_o;
    logic             r_vld;
    logic             r_done;

    logic             w_sweeping;
    logic             w_slot_free;
    logic             w_accept;
    logic             w_sweep_load;
    logic             w_load;
    logic [SEL_W-1:0] w_sel;
    logic             w_en;
    logic [OUT_W-1:0] w_dec;

    assign w_sweeping   = (r_state == SWEEP);
    assign w_slot_free  = !r_vld || out_ready;
    assign in_ready     = !w_sweeping && w_slot_free && !sweep_start;
    assign w_accept     = in_valid && in_ready;
    assign w_sweep_load = w_sweeping && w_slot_free;
    assign w_load       = w_accept || w_sweep_load;

    // in_sel only reaches the decoder when it is actually accepted.
    assign w_sel = w_sweeping ? r_cnt : (w_accept ? in_sel : '0);
    assign w_en  = w_sweeping ? 1'b1 : in_en;

    decoder_onehot #(
        .SEL_W (SEL_W)
    ) u_onehot (
        .I  (w_sel),
        .en (w_en),
        .O  (w_dec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_o     <= '0;
            r_vld   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (w_load) begin
                r_o   <= w_dec;
                r_idx <= w_sel;
                r_vld <= 1'b1;
            end else if (out_ready) begin
                r_vld <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (sweep_start) begin
                        r_state <= SWEEP;
                        r_cnt   <= '0;
                    end
                end
                SWEEP: begin
                    if (w_slot_free) begin
                        if (&r_cnt) begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                            r_done  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + SEL_W'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign sweep_busy = w_sweeping;
    assign sweep_done = r_done;
    assign out_valid  = r_vld;
    assign O          = r_o;
    assign out_idx    = r_idx;

endmodule

// File: tb/tb_decoder_pipe.sv
// Directed bench for decoder_pipe at SEL_W=3 (main) and SEL_W=5 (width check).
module tb_decoder_pipe;

    logic       clk = 1'b0;
    logic       rst;

    logic       in_valid, in_ready, in_en, sweep_start, sweep_busy, sweep_done;
    logic       out_valid, out_ready;
    logic [2:0] in_sel, out_idx;
    logic [7:0] O;

    logic        b_in_valid, b_in_ready, b_in_en, b_sweep_start, b_sweep_busy, b_sweep_done;
    logic        b_out_valid, b_out_ready;
    logic [4:0]  b_in_sel, b_out_idx;
    logic [31:0] b_O;

    int errors = 0;
    int checks = 0;
    int busy_cnt;
    int done_cnt;

    always #5 clk = ~clk;

    decoder_pipe #(.SEL_W(3)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_en(in_en),
        .sweep_start(sweep_start), .sweep_busy(sweep_busy), .sweep_done(sweep_done),
        .out_valid(out_valid), .out_ready(out_ready), .O(O), .out_idx(out_idx)
    );

    decoder_pipe #(.SEL_W(5)) dut5 (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_sel(b_in_sel), .in_en(b_in_en),
        .sweep_start(b_sweep_start), .sweep_busy(b_sweep_busy), .sweep_done(b_sweep_done),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .O(b_O), .out_idx(b_out_idx)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_sel = '0; in_en = 1'b1; sweep_start = 1'b0; out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_sel = '0; b_in_en = 1'b1; b_sweep_start = 1'b0; b_out_ready = 1'b1;

        // Reset
        tick(); tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_O", 64'(O), 64'd0);
        chk("rst_out_idx", 64'(out_idx), 64'd0);
        chk("rst_busy", 64'(sweep_busy), 64'd0);
        chk("rst_done", 64'(sweep_done), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst5_out_valid", 64'(b_out_valid), 64'd0);
        rst = 1'b0;

        // Decode all selectors back to back
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_sel = 3'(i); in_en = 1'b1;
            tick();
            chk("dec_O", 64'(O), 64'd1 << i);
            chk("dec_idx", 64'(out_idx), 64'(i));
            chk("dec_vld", 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("drain_vld", 64'(out_valid), 64'd0);

        // Enable gating
        in_valid = 1'b1; in_sel = 3'd5; in_en = 1'b0;
        tick();
        chk("en0_O", 64'(O), 64'h00);
        chk("en0_idx", 64'(out_idx), 64'd5);
        chk("en0_vld", 64'(out_valid), 64'd1);

        // Backpressure
        in_sel = 3'd3; in_en = 1'b1;
        tick();
        chk("bp_load_O", 64'(O), 64'h08);
        out_ready = 1'b0; in_sel = 3'd6;
        #1;
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_O", 64'(O), 64'h08);
            chk("bp_hold_idx", 64'(out_idx), 64'd3);
            chk("bp_hold_rdy", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_next_O", 64'(O), 64'h40);
        chk("bp_next_idx", 64'(out_idx), 64'd6);
        in_valid = 1'b0;
        tick();
        chk("bp_drain_vld", 64'(out_valid), 64'd0);

        // Sweep with simultaneous in_valid
        sweep_start = 1'b1; in_valid = 1'b1; in_sel = 3'd2;
        #1;
        chk("sw_in_ready", 64'(in_ready), 64'd0);
        tick();
        chk("sw_entry_vld", 64'(out_valid), 64'd0);
        sweep_start = 1'b0; in_valid = 1'b0;
        busy_cnt = (sweep_busy === 1'b1) ? 1 : 0;
        done_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("sw_O", 64'(O), 64'd1 << k);
            chk("sw_idx", 64'(out_idx), 64'(k));
            chk("sw_done", 64'(sweep_done), (k == 7) ? 64'd1 : 64'd0);
            if (sweep_busy === 1'b1) busy_cnt++;
            if (sweep_done === 1'b1) done_cnt++;
        end
        tick();
        if (sweep_done === 1'b1) done_cnt++;
        chk("sw_busy_cycles", 64'(busy_cnt), 64'd8);
        chk("sw_done_pulses", 64'(done_cnt), 64'd1);
        chk("sw_after_vld", 64'(out_valid), 64'd0);
        chk("sw_after_busy", 64'(sweep_busy), 64'd0);

        // Sweep with a 2-cycle stall at 0x04
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("st_O", 64'(O), 64'd1 << k);
            if (k == 2) begin
                out_ready = 1'b0;
                tick();
                chk("st_hold1_O", 64'(O), 64'h04);
                tick();
                chk("st_hold2_O", 64'(O), 64'h04);
                chk("st_hold_busy", 64'(sweep_busy), 64'd1);
                out_ready = 1'b1;
            end
        end
        chk("st_done", 64'(sweep_done), 64'd1);
        tick();

        // Reset in the middle of a sweep
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("mr_pre_O", 64'(O), 64'h10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_vld", 64'(out_valid), 64'd0);
        chk("mr_busy", 64'(sweep_busy), 64'd0);
        chk("mr_done", 64'(sweep_done), 64'd0);
        done_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (sweep_done === 1'b1) done_cnt++;
        end
        chk("mr_no_done", 64'(done_cnt), 64'd0);
        chk("mr_in_ready", 64'(in_ready), 64'd1);

        // SEL_W = 5 width check
        b_in_valid = 1'b1; b_in_en = 1'b1; b_in_sel = 5'd31;
        tick();
        chk("w5_O31", 64'(b_O), 64'h8000_0000);
        chk("w5_idx31", 64'(b_out_idx), 64'd31);
        b_in_sel = 5'd0;
        tick();
        chk("w5_O0", 64'(b_O), 64'h1);
        b_in_sel = 5'd17;
        tick();
        chk("w5_O17", 64'(b_O), 64'h0002_0000);
        b_in_valid = 1'b0;
        tick();
        chk("w5_drain", 64'(b_out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
